// File: rtl/tick_scheduler.sv
// tick_scheduler: shared base-tick prescaler feeding CHANNELS programmable
// tick generators, reconfigured at run time through a valid/ready port.
// Ports: clk_in, rst (sync, active-high); cfg_valid/cfg_ready handshake with
// cfg_ch/cfg_div/cfg_en request fields; base_tick, per-channel tick pulses
// and per-channel active status.
// Option: define TICK_SCHED_IMMEDIATE_EN to apply requests the cycle after
// acceptance instead of aligning them to base_tick.
module tick_scheduler #(
  parameter int SRC_FREQ  = 100_000_000,
  parameter int BASE_FREQ = 1000,
  parameter int CHANNELS  = 4,
  parameter int DIV_W     = 16,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic                cfg_en,
  output logic                base_tick,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] active
);

  localparam int PRESCALE = SRC_FREQ / BASE_FREQ;
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      pcnt      <= '0;
      base_tick <= 1'b0;
    end else begin
      base_tick <= (pcnt == PLAST);
      pcnt      <= (pcnt == PLAST) ? '0 : pcnt + PW'(1);
    end
  end

`ifdef TICK_SCHED_IMMEDIATE_EN
  typedef enum logic [1:0] {IDLE, APPLY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SYNC, APPLY} state_t;
`endif

  state_t state, state_nx;

  logic [CH_W-1:0]  ch_q;
  logic [DIV_W-1:0] div_q;
  logic             en_q;
  logic             accept;
  logic             apply;

  assign accept = cfg_valid & cfg_ready;
  assign apply  = (state == APPLY);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state <= IDLE;
      ch_q  <= '0;
      div_q <= '0;
      en_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        ch_q  <= cfg_ch;
        div_q <= cfg_div;
        en_q  <= cfg_en;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    cfg_ready = 1'b0;
    unique case (state)
      IDLE: begin
        cfg_ready = 1'b1;
`ifdef TICK_SCHED_IMMEDIATE_EN
        if (cfg_valid) state_nx = APPLY;
`else
        if (cfg_valid) state_nx = SYNC;
`endif
      end
`ifndef TICK_SCHED_IMMEDIATE_EN
      // Entered the cycle after acceptance, so a base_tick seen
      // here is always strictly later than the accepting cycle.
      SYNC: if (base_tick) state_nx = APPLY;
`endif
      APPLY: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DIV_W-1:0] dv;
    logic [DIV_W-1:0] ct;
    logic             en;
    logic             tk;
    logic             hit;

    // Out-of-range indices never match any channel, so APPLY is a no-op.
    assign hit       = apply && (ch_q == CH_W'(c));
    assign active[c] = en && (dv != '0);
    assign tick[c]   = tk;

    always_ff @(posedge clk_in) begin
      if (rst) begin
        dv <= '0;
        ct <= '0;
        en <= 1'b0;
        tk <= 1'b0;
      end else if (hit) begin
        // Takes priority over a coincident base_tick so the new
        // period starts cleanly from zero.
        dv <= div_q;
        en <= en_q;
        ct <= '0;
        tk <= 1'b0;
      end else if (base_tick && active[c]) begin
        if (ct == dv - DIV_W'(1)) begin
          ct <= '0;
          tk <= 1'b1;
        end else begin
          ct <= ct + DIV_W'(1);
          tk <= 1'b0;
        end
      end else begin
        tk <= 1'b0;
        if (!active[c]) ct <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: scoreboard bench for tick_scheduler (PRESCALE=10).
// Expected tick cycles are queued per channel at configuration time.
module tb_tick_scheduler;

  localparam int LIM = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_valid3 = 1'b0;
  logic       cfg_en = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_ready, base_tick;
  logic       cfg_ready3, base_tick3;
  logic [3:0] tick, active;
  logic [2:0] tick3, active3;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   q[4][$];
  logic [3:0] exp_act = '0;
  logic [2:0] exp_act3 = '0;

  tick_scheduler #(
    .SRC_FREQ(1000), .BASE_FREQ(100), .CHANNELS(4), .DIV_W(8)
  ) dut (
    .clk_in(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en),
    .base_tick(base_tick), .tick(tick), .active(active)
  );

  tick_scheduler #(
    .SRC_FREQ(1000), .BASE_FREQ(100), .CHANNELS(3), .DIV_W(8)
  ) dut3 (
    .clk_in(clk), .rst(rst),
    .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en),
    .base_tick(base_tick3), .tick(tick3), .active(active3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Scoreboard: base_tick is due on cycles 10, 20, ...; ticks are popped
  // from the per-channel queues as they appear.
  always @(negedge clk) begin
    if (mon_en) begin
      logic bt;
      bt = (cyc >= 10) && (cyc % 10 == 0);
      total++;
      if (base_tick !== bt || base_tick3 !== bt) begin
        bad++;
        $display("FAIL base_tick cyc=%0d got=%b/%b want=%b",
                 cyc, base_tick, base_tick3, bt);
      end
      for (int c = 0; c < 4; c++) begin
        while (q[c].size() > 0 && q[c][0] < cyc) begin
          total++;
          bad++;
          $display("FAIL missed tick ch=%0d want_cyc=%0d now=%0d",
                   c, q[c][0], cyc);
          void'(q[c].pop_front());
        end
        if (tick[c]) begin
          total++;
          if (q[c].size() == 0 || q[c][0] != cyc) begin
            bad++;
            $display("FAIL unexpected tick ch=%0d cyc=%0d next_want=%0d",
                     c, cyc, (q[c].size() > 0) ? q[c][0] : -1);
          end else begin
            void'(q[c].pop_front());
          end
        end
      end
    end
  end

  task automatic do_reset(input int n);
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_valid3 = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) q[c].delete();
    exp_act = '0;
    exp_act3 = '0;
    mon_en = 1'b1;
  endtask

  task automatic start(input bit d3, input int ch, input int dv,
                       input bit e, output int s);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    cfg_ch = 2'(ch);
    cfg_div = 8'(dv);
    cfg_en = e;
    if (d3) cfg_valid3 = 1'b1;
    else cfg_valid = 1'b1;
    s = -1;
    while (s < 0 && n < 40) begin
      @(negedge clk);
      if ((d3 ? cfg_ready3 : cfg_ready) === 1'b1) s = cyc;
      n++;
    end
    if (s < 0) begin
      total++;
      bad++;
      $display("FAIL accept timeout d3=%0d ch=%0d", d3, ch);
      s = cyc;
    end
  endtask

  task automatic finish(input bit d3, input int s, input int ch,
                        input int dv, input bit e, input bit hold,
                        input int nch, input int ndv, input bit nen);
    int a, nb;
    logic [3:0] old4, new4;
    logic [2:0] old3, new3;
`ifdef TICK_SCHED_IMMEDIATE_EN
    a = s + 1;
`else
    a = (s / 10 + 1) * 10 + 1;
`endif
    old4 = exp_act;
    new4 = exp_act;
    old3 = exp_act3;
    new3 = exp_act3;
    if (d3) begin
      if (ch < 3) new3[ch] = e && (dv != 0);
    end else begin
      new4[ch] = e && (dv != 0);
      while (q[ch].size() > 0 && q[ch][$] > a) void'(q[ch].pop_back());
      if (e && dv != 0) begin
        nb = (a / 10 + 1) * 10;
        for (int t = nb + 10 * (dv - 1) + 1; t < LIM; t += 10 * dv)
          q[ch].push_back(t);
      end
    end
    @(posedge clk);
    #1;
    if (hold) begin
      cfg_ch = 2'(nch);
      cfg_div = 8'(ndv);
      cfg_en = nen;
    end else begin
      cfg_valid = 1'b0;
      cfg_valid3 = 1'b0;
    end
    for (int t = s + 1; t <= a + 1; t++) begin
      @(negedge clk);
      total++;
      if (d3) begin
        if (cfg_ready3 !== (t > a) || active3 !== (t > a ? new3 : old3)) begin
          bad++;
          $display("FAIL cfg3 cyc=%0d ready=%b want=%b active=%b want=%b",
                   t, cfg_ready3, t > a, active3, t > a ? new3 : old3);
        end
      end else begin
        if (cfg_ready !== (t > a) || active !== (t > a ? new4 : old4)) begin
          bad++;
          $display("FAIL cfg cyc=%0d ready=%b want=%b active=%b want=%b",
                   t, cfg_ready, t > a, active, t > a ? new4 : old4);
        end
      end
    end
    exp_act = new4;
    exp_act3 = new3;
  endtask

  task automatic cfg(input int ch, input int dv, input bit e);
    int s;
    start(1'b0, ch, dv, e, s);
    finish(1'b0, s, ch, dv, e, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset(3);
    for (int t = 0; t < 35; t++) begin
      @(negedge clk);
      total++;
      if ({tick, active, cfg_ready} !== 9'b1) begin
        bad++;
        $display("FAIL reset idle cyc=%0d tick=%b active=%b ready=%b",
                 cyc, tick, active, cfg_ready);
      end
    end
  endtask

  task automatic test_single();
    int s;
    do_reset(2);
    while (cyc % 10 != 9) @(negedge clk);
    // Accept in a base_tick cycle: SYNC must wait for the next one.
    start(1'b0, 1, 3, 1'b1, s);
    finish(1'b0, s, 1, 3, 1'b1, 1'b0, 0, 0, 1'b0);
    repeat (100) @(negedge clk);
  endtask

  task automatic test_period_change();
    do_reset(2);
    cfg(0, 2, 1'b1);
    cfg(1, 3, 1'b1);
    repeat (45) @(negedge clk);
    cfg(1, 5, 1'b1);
    repeat (130) @(negedge clk);
  endtask

  task automatic test_disable_invalid();
    int s, n;
    do_reset(2);
    cfg(0, 1, 1'b1);
    cfg(2, 0, 1'b1);
    repeat (40) @(negedge clk);
    cfg(2, 4, 1'b0);
    repeat (50) @(negedge clk);
    start(1'b1, 0, 2, 1'b1, s);
    finish(1'b1, s, 0, 2, 1'b1, 1'b0, 0, 0, 1'b0);
    start(1'b1, 3, 1, 1'b1, s);
    finish(1'b1, s, 3, 1, 1'b1, 1'b0, 0, 0, 1'b0);
    n = 0;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (tick3[0]) n++;
    end
    total++;
    if (n != 4 || active3 !== 3'b001) begin
      bad++;
      $display("FAIL invalid ch ticks=%0d want=4 active3=%b want=001",
               n, active3);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    do_reset(2);
    start(1'b0, 1, 2, 1'b1, s);
    // Second request sits on the bus while the first is in flight.
    finish(1'b0, s, 1, 2, 1'b1, 1'b1, 0, 3, 1'b1);
    s = cyc;
    finish(1'b0, s, 0, 3, 1'b1, 1'b0, 0, 0, 1'b0);
    repeat (80) @(negedge clk);
`ifndef TICK_SCHED_IMMEDIATE_EN
    start(1'b0, 2, 1, 1'b1, s);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    do_reset(2);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      total++;
      if (active !== 4'b0 || cfg_ready !== 1'b1) begin
        bad++;
        $display("FAIL reset in sync cyc=%0d active=%b ready=%b",
                 cyc, active, cfg_ready);
      end
    end
`endif
  endtask

`ifdef TICK_SCHED_IMMEDIATE_EN
  task automatic test_immediate();
    int s;
    do_reset(2);
    while (cyc % 10 != 8) @(negedge clk);
    // APPLY lands on a base_tick cycle, which must not count.
    start(1'b0, 0, 1, 1'b1, s);
    finish(1'b0, s, 0, 1, 1'b1, 1'b0, 0, 0, 1'b0);
    repeat (60) @(negedge clk);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_period_change();
    test_disable_invalid();
    test_back_to_back();
`ifdef TICK_SCHED_IMMEDIATE_EN
    test_immediate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
